// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light and state encodings shared by the intersection controller
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    S_AG = 2'd0,
    S_AY = 2'd1,
    S_BG = 2'd2,
    S_BY = 2'd3
  } state_t;

  // Phase timer ceiling: GREEN_MAX-1, raised if needed so a long yellow can still expire.
  function automatic int sat_limit(input int green_max, input int yellow_cyc);
    return ((green_max > yellow_cyc) ? green_max : yellow_cyc) - 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating phase counter, cleared on every phase change
module phase_timer #(
  parameter int CNT_W = 8,
  parameter int MAX   = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != MAX_V) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - two-road Moore light sequencer with min/max green and fixed yellow
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = 5,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_CYC - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic             clr;

  phase_timer #(
    .CNT_W (CNT_W),
    .MAX   (sat_limit(GREEN_MAX, YELLOW_CYC))
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .cnt (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_AG;
    end else begin
      state_q <= state_d;
    end
  end

  // Green ends once minimum is served and either the own road is empty or the
  // other road has waited the full maximum; yellow ignores the sensors.
  always_comb begin
    state_d = state_q;
    la      = RED;
    lb      = RED;
    case (state_q)
      S_AG: begin
        la = GREEN;
        if (cnt >= GMIN_M1 && (!ta || (tb && cnt == GMAX_M1))) state_d = S_AY;
      end
      S_AY: begin
        la = YELLOW;
        if (cnt == YEL_M1) state_d = S_BG;
      end
      S_BG: begin
        lb = GREEN;
        if (cnt >= GMIN_M1 && (!tb || (ta && cnt == GMAX_M1))) state_d = S_BY;
      end
      S_BY: begin
        lb = YELLOW;
        if (cnt == YEL_M1) state_d = S_AG;
      end
      default: state_d = S_AG;
    endcase
  end

  assign clr   = (state_d != state_q);
  assign state = state_q;

endmodule
